// File: rtl/uart_pkg.sv
// Shared types for the monitor-control UART receive path.
// Deframer state encoding and the FIFO entry layout.
package uart_pkg;

   localparam int DATA_BITS = 8;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP,
      WAIT_HIGH
   } rx_state_t;

   typedef struct packed {
      logic                 frame_err;
      logic                 parity_err;
      logic [DATA_BITS-1:0] data;
   } rx_entry_t;

endpackage

// File: rtl/uart_rx_fifo.sv
// Synchronous FIFO of received entries with registered pointers.
// Full-and-pop accepts the push; empty-and-pop is ignored.
module uart_rx_fifo
   import uart_pkg::*;
#(
   parameter int DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     push,
   input  rx_entry_t                wr_entry,
   input  logic                     pop,
   output rx_entry_t                rd_entry,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     full,
   output logic                     empty,
   output logic                     push_ok,
   output logic                     pop_ok
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   rx_entry_t        mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;

   assign full     = (count == CW'(DEPTH));
   assign empty    = (count == '0);
   assign pop_ok   = pop & ~empty;
   assign push_ok  = push & (~full | pop_ok);
   assign rd_entry = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (!reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         for (int i = 0; i < DEPTH; i++)
            mem[i] <= '0;
      end else begin
         if (push_ok) begin
            mem[wr_ptr] <= wr_entry;
            wr_ptr      <= wr_ptr + AW'(1);
         end
         if (pop_ok)
            rd_ptr <= rd_ptr + AW'(1);
         count <= count + CW'(push_ok) - CW'(pop_ok);
      end
   end

endmodule

// File: rtl/uart_rx.sv
// 8E1 UART receiver with 16x oversampling, entry FIFO,
// sticky overrun and RTS flow control toward the host.
module uart_rx
   import uart_pkg::*;
#(
   parameter int OVERSAMPLE = 16,
   parameter int FIFO_DEPTH = 8,
   parameter int RTS_MARGIN = 2
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       baud_tick,
   input  logic       uart_rxd,
   output logic       uart_rts,
   output logic [7:0] rx_data,
   output logic       rx_parity_err,
   output logic       rx_frame_err,
   output logic       rx_valid,
   input  logic       rx_ready,
   output logic       rx_overrun,
   input  logic       ovr_clr,
   output logic       busy
);

   localparam int CNT_W = $clog2(OVERSAMPLE);
   localparam int BIT_W = $clog2(DATA_BITS);
   localparam int CW    = $clog2(FIFO_DEPTH) + 1;

   localparam logic [CNT_W-1:0] HALF = CNT_W'(OVERSAMPLE / 2 - 1);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(OVERSAMPLE - 1);
   localparam logic [CW-1:0]    RTS_LVL = CW'(FIFO_DEPTH - RTS_MARGIN);

   logic [1:0]           sync_q;
   logic                 rxd_s;

   rx_state_t            state_q, state_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic [BIT_W-1:0]     bit_q, bit_d;
   logic [DATA_BITS-1:0] data_q, data_d;
   logic                 perr_q, perr_d;
   logic                 push;

   rx_entry_t            wr_entry;
   rx_entry_t            rd_entry;
   logic [CW-1:0]        count;
   logic [CW-1:0]        count_nxt;
   logic                 full;
   logic                 empty;
   logic                 push_ok;
   logic                 pop_ok;
   logic                 drop;

   always_ff @(posedge clk) begin
      if (!reset)
         sync_q <= 2'b11;
      else
         sync_q <= {sync_q[0], uart_rxd};
   end

   assign rxd_s = sync_q[1];

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         bit_q   <= '0;
         data_q  <= '0;
         perr_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         bit_q   <= bit_d;
         data_q  <= data_d;
         perr_q  <= perr_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      bit_d   = bit_q;
      data_d  = data_q;
      perr_d  = perr_q;
      push    = 1'b0;
      if (baud_tick) begin
         unique case (state_q)
            IDLE: begin
               if (!rxd_s) begin
                  state_d = START;
                  cnt_d   = '0;
               end
            end
            START: begin
               // Qualify the start bit at its midpoint
               if (cnt_q == HALF) begin
                  cnt_d = '0;
                  bit_d = '0;
                  state_d = rxd_s ? IDLE : DATA;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
            DATA: begin
               if (cnt_q == LAST) begin
                  cnt_d  = '0;
                  data_d = {rxd_s, data_q[DATA_BITS-1:1]};
                  bit_d  = bit_q + BIT_W'(1);
                  if (bit_q == BIT_W'(DATA_BITS - 1))
                     state_d = PARITY;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
            PARITY: begin
               if (cnt_q == LAST) begin
                  cnt_d   = '0;
                  perr_d  = ^{data_q, rxd_s};
                  state_d = STOP;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
            STOP: begin
               if (cnt_q == LAST) begin
                  cnt_d   = '0;
                  push    = 1'b1;
                  state_d = rxd_s ? IDLE : WAIT_HIGH;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
            WAIT_HIGH: begin
               if (rxd_s)
                  state_d = IDLE;
            end
            default: state_d = IDLE;
         endcase
      end
   end

   assign wr_entry = '{frame_err:  ~rxd_s,
                       parity_err: perr_q,
                       data:       data_q};

   uart_rx_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk      (clk),
      .reset    (reset),
      .push     (push),
      .wr_entry (wr_entry),
      .pop      (rx_valid & rx_ready),
      .rd_entry (rd_entry),
      .count    (count),
      .full     (full),
      .empty    (empty),
      .push_ok  (push_ok),
      .pop_ok   (pop_ok)
   );

   assign drop      = push & full & ~pop_ok;
   assign count_nxt = count + CW'(push_ok) - CW'(pop_ok);

   always_ff @(posedge clk) begin
      if (!reset) begin
         rx_overrun <= 1'b0;
         uart_rts   <= 1'b1;
      end else begin
         if (drop)
            rx_overrun <= 1'b1;
         else if (ovr_clr)
            rx_overrun <= 1'b0;
         uart_rts <= (count_nxt >= RTS_LVL);
      end
   end

   assign rx_valid      = ~empty;
   assign rx_data       = rd_entry.data;
   assign rx_parity_err = rd_entry.parity_err;
   assign rx_frame_err  = rd_entry.frame_err;
   assign busy          = (state_q != IDLE);

endmodule

// File: doc/uart_rx.md
# uart_rx

Serial receiver for the monitor control UART: the receive-side counterpart to the board's transmit path. Samples `uart_rxd` using the 16× oversampling enable from a `baud_generator` instance, then deframes 1 start, 8 data (LSB first), 1 even-parity and 1 stop bit. Received bytes and their error flags go into a small FIFO that the command logic drains through a valid/ready handshake. Drives `uart_rts` for hardware flow control toward the host.

## Interface
- `OVERSAMPLE`, 16: baud_tick pulses per bit; even, ≥8.
- `FIFO_DEPTH`, 8: entries; power of two, ≥4.
- `RTS_MARGIN`, 2: free entries at which RTS is deasserted.

- `clk`  in  1  system clock (50 MHz).
- `reset`  in  1  synchronous, active-low.
- `baud_tick`  in  1  one-`clk` enable pulse at OVERSAMPLE×baud.
- `uart_rxd`  in  1  asynchronous serial input, idle high.
- `uart_rts`  out  1  active-low request-to-send: 0 means the host may send.
- `rx_data`  out  8  FIFO head data.
- `rx_parity_err`  out  1  FIFO head parity error.
- `rx_frame_err`  out  1  FIFO head stop-bit error.
- `rx_valid`  out  1  FIFO non-empty.
- `rx_ready`  in  1  consumer accepts the head entry.
- `rx_overrun`  out  1  sticky: a byte was dropped because the FIFO was full.
- `ovr_clr`  in  1  clears `rx_overrun`.
- `busy`  out  1  deframer is not in IDLE.

## Operation
- `uart_rxd` passes through a 2-flop synchronizer (reset value 1) to give `rxd_s`. All state advances only on `clk` cycles where `baud_tick`=1. The tick counter `cnt` is width clog2(OVERSAMPLE).
- IDLE: when `rxd_s`=0, go to START with cnt=0.
- START: cnt increments. At cnt=OVERSAMPLE/2−1, if `rxd_s`=0 go to DATA with cnt=0 and bit index 0. Otherwise it was a glitch: return to IDLE with no push.
- DATA: at cnt=OVERSAMPLE−1, shift `rxd_s` in at the MSB (the byte is received LSB first) and set cnt=0. After bit 7, go to PARITY.
- PARITY: at cnt=OVERSAMPLE−1, compute parity_err = XOR(data[7:0], `rxd_s`). Go to STOP.
- STOP: at cnt=OVERSAMPLE−1, set frame_err = ~`rxd_s` and push {frame_err, parity_err, data}. If `rxd_s`=1, go to IDLE. Otherwise go to WAIT_HIGH.
- WAIT_HIGH: stay until a tick samples `rxd_s`=1, then go to IDLE. A held-low break therefore pushes exactly one entry (0x00, frame_err=1).
- FIFO:
  - Pop happens when `rx_valid`&`rx_ready`.
  - A push while full is dropped and sets `rx_overrun`. A push and pop in the same cycle while full both succeed; the count is unchanged and overrun is not set.
  - A pop while empty is ignored. Pointers wrap modulo FIFO_DEPTH.
- `rx_overrun` is set by a dropped push and cleared by `ovr_clr`. If both happen in the same cycle, set wins.
- `uart_rts` is registered: 1 when count ≥ FIFO_DEPTH−RTS_MARGIN, otherwise 0.
- Reset mid-frame aborts the frame with no push. The FIFO is emptied and all storage is cleared to 0.

## Timing
- Reset values: `rx_data`=0x00, `rx_parity_err`=0, `rx_frame_err`=0, `rx_valid`=0, `rx_overrun`=0, `busy`=0, `uart_rts`=1.
  - `uart_rts` falls to 0 on the first cycle after `reset` returns high.
- Line to `rxd_s`: 2 `clk` cycles.
- Stop-bit sample tick in cycle T: entry is visible with `rx_valid`=1 at T+1, and `uart_rts` reflects the new count at T+1.
- Pop in cycle T: head and `rx_valid` update at T+1. Outputs are stable while `rx_valid`=1 and `rx_ready`=0.
- Each data bit is sampled OVERSAMPLE ticks after the previous sample, with the start bit qualified at its midpoint.
  - At 115200 baud with OVERSAMPLE=16, `baud_tick` runs at about 1.843 MHz, roughly one pulse per 27 `clk` cycles.

## Structure
- `uart_pkg` holds:
  - `rx_state_t` enum: IDLE, START, DATA, PARITY, STOP, WAIT_HIGH.
  - `rx_entry_t` packed struct: {frame_err, parity_err, data[7:0]}.
  - `DATA_BITS`=8.
- Sub-module `uart_rx_fifo`: parameterized synchronous FIFO of `rx_entry_t`, with `count`, `full`, `empty` and registered pointers. The deframer FSM stays in `uart_rx`.

## Test plan
- Frame 0xA5 with parity bit 0 and stop bit 1 → one entry: `rx_data`=0xA5, both error flags 0, `busy` back to 0 after the stop bit.
- Frame 0x01 with parity bit 0 → `rx_data`=0x01, `rx_parity_err`=1.
- Low pulse lasting 5 ticks, then high → no push, `rx_valid` stays 0, back in IDLE.
- 9 back-to-back frames 0x00..0x08 with `rx_ready`=0:
  - `uart_rts`=1 after the 6th byte.
  - `rx_overrun`=1 after the 9th byte.
  - Draining yields 0x00..0x07.
  - `ovr_clr` then clears `rx_overrun`.
- Line held low for 40 bit times → exactly one entry: 0x00 with `rx_frame_err`=1 and `rx_parity_err`=0. A 0x3C frame sent after the line returns high is received cleanly.
- `reset` asserted during DATA bit 4 → no entry, all outputs at reset values. The next frame, 0x5A, is received correctly.
